// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, start/busy/done handshake.
// Optional macro BIN_TO_BCD_BLANK_EN adds a registered leading-zero blank mask. Rev 1.0
`default_nettype none

module bin_to_bcd_seq #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic bit digits_ok(input int in_w, input int digits);
    logic [255:0] p;
    logic [255:0] m;
    p = 256'd1;
    for (int i = 0; i < digits; i++) p = p * 256'd10;
    m = (256'd1 << in_w) - 256'd1;
    return p > m;
  endfunction

  generate
    if (!digits_ok(IN_W, DIGITS)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small to hold 2**IN_W-1");
    end
  endgenerate

  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t                 state, state_next;
  logic [IN_W-1:0]        shift_q;
  logic [4*DIGITS-1:0]    scratch_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   load, finish;
  logic [4*DIGITS-1:0]    adj;
  logic [4*DIGITS+IN_W-1:0] shifted;

  // Adjust every nibble >=5 before shifting so the doubled digit carries correctly.
  always_comb begin
    adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
    shifted = {adj, shift_q} << 1;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = CONV;
        load       = 1'b1;
      end
      CONV: if (cnt_q == CNT_LAST) begin
        state_next = IDLE;
        finish     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CONV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      state <= state_next;
      done  <= finish;
      if (load) begin
        shift_q   <= bin;
        scratch_q <= '0;
        cnt_q     <= '0;
      end else if (state == CONV) begin
        shift_q   <= shifted[IN_W-1:0];
        scratch_q <= shifted[4*DIGITS+IN_W-1:IN_W];
        cnt_q     <= cnt_q + CNT_ONE;
      end
      // bcd only moves on the done edge so the display never sees a partial value.
      if (finish) bcd <= shifted[4*DIGITS+IN_W-1:IN_W];
    end
  end

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] mask;
  logic              all_zero;

  always_comb begin
    mask     = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (shifted[IN_W+4*i +: 4] == 4'd0);
      mask[i]  = all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         blank <= '0;
    else if (finish) blank <= mask;
  end
`else
  assign blank = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized self-checking bench for bin_to_bcd_seq against a decimal reference model.
`default_nettype none

module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int total = 0;
  int bad   = 0;
  logic [19:0] cur_bcd;

  bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] exp_blank(input int v);
    logic [4:0] m;
    int p;
    m = '0;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      if (v < p) m[i] = 1'b1;
      p = p * 10;
    end
`ifdef BIN_TO_BCD_BLANK_EN
    return m;
`else
    return 5'b0;
`endif
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered just after a negedge; leaves just after the negedge of the done cycle.
  task automatic run_conv(input logic [15:0] v, input int poke);
    logic [19:0] prev;
    prev  = cur_bcd;
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 1) begin
        start = 1'b0;
        bin   = 16'($urandom);
      end
      if (poke != 0 && j == poke) begin
        start = 1'b1;
        bin   = 16'd999;
      end
      if (poke != 0 && j == poke + 1) start = 1'b0;
      check_val("busy_conv", 32'(busy), 32'd1);
      check_val("done_conv", 32'(done), 32'd0);
      check_val("bcd_hold", 32'(bcd), 32'(prev));
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    check_val("done_pulse", 32'(done), 32'd1);
    check_val("busy_done", 32'(busy), 32'd0);
    check_val("bcd_result", 32'(bcd), 32'(to_bcd(int'(v))));
    check_val("blank_result", 32'(blank), 32'(exp_blank(int'(v))));
    cur_bcd = to_bcd(int'(v));
  endtask

  task automatic idle_check();
    @(negedge clk);
    check_val("done_idle", 32'(done), 32'd0);
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("bcd_idle", 32'(bcd), 32'(cur_bcd));
  endtask

  task automatic reset_check();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_bcd", 32'(bcd), 32'd0);
    check_val("rst_blank", 32'(blank), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    cur_bcd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_check();
    rst = 1'b0;

    run_conv(16'd0, 0);
    idle_check();
    run_conv(16'd65535, 0);
    idle_check();
    run_conv(16'd12345, 0);
    run_conv(16'd9, 0);
    idle_check();
    run_conv(16'd4321, 5);
    idle_check();
    idle_check();

    run_conv(16'd42, 0);
    idle_check();
    start = 1'b1;
    bin   = 16'd777;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_check();
    rst = 1'b0;
    cur_bcd = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("no_done_after_rst", 32'(done), 32'd0);
    end
    run_conv(16'd777, 0);
    idle_check();

    run_conv(16'd100, 0);
    idle_check();
    run_conv(16'd250, 0);
    idle_check();

    for (int i = 0; i < 20; i++) begin
      logic [15:0] v;
      int sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      v = 16'($urandom_range(0, 99));
      else if (sel == 1) v = 16'($urandom_range(9990, 10009));
      else               v = 16'($urandom);
      run_conv(v, 0);
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
